rgb_pwm_engine: RTL and testbench
=================================

Name: rgb_pwm_engine

Overview:
Parametrised N-channel PWM LED driver. It is the successor to the fixed single-pattern RGB lab top and drives R/G/B (or more) LED pins from per-channel duty values. It adds a clock prescaler, glitch-free shadowed duty updates and four lighting modes: static, breathing, blink and off. It sits between board-level control logic (switches/registers) and the LED output pins.

Parameters:
NUM_CH, 3, number of PWM channels (bit 0 = R, 1 = G, 2 = B for the default).
PWM_WIDTH, 8, duty/counter resolution in bits; PWM period = 2^PWM_WIDTH-1 ticks.
PRESCALE, 4, clk cycles per PWM tick (>=1).
STEP_PERIODS, 2, PWM periods per breathing envelope step.
BLINK_PERIODS, 64, PWM periods per blink half-phase (on or off).

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
mode  input  2  00 static, 01 breathing, 10 blink, 11 off.
duty_in  input  NUM_CH*PWM_WIDTH  channel k duty at [k*PWM_WIDTH +: PWM_WIDTH].
load  input  1  1-cycle strobe: capture duty_in into shadow register.
pwm_out  output  NUM_CH  registered PWM outputs.
period_tick  output  1  1-cycle pulse on the first clk of each PWM period.
level  output  PWM_WIDTH  current breathing envelope value.

Behaviour:
- Reset (async, immediate): pwm_out=0, period_tick=0, level=0, prescaler=0, pwm counter cnt=0, shadow and active duty=0, active mode=11 (off), breath direction=up, blink phase=on, step/blink counters=0.
- Prescaler: counts 0..PRESCALE-1. tick is high on clocks where the prescaler equals PRESCALE-1. With PRESCALE=1, tick is high every clock.
- cnt advances on tick, 0..2^W-2, then wraps to 0. Period boundary = tick with cnt at 2^W-2.
- Shadow: load=1 captures duty_in on that edge. A later load before the boundary overwrites it (last wins).
- Active update: at each period boundary, active duty <= shadow and active mode <= mode. If load coincides with the boundary, the newly loaded value lands in shadow only and becomes active at the following boundary.
- period_tick: registered. It is 1 for exactly one clk, the clk after the boundary edge (cnt==0 first cycle).
- Effective duty per channel, eff:
  - static: eff = duty.
  - breathing: eff = (duty*level) >> PWM_WIDTH, using a 2W-bit product and taking the upper W bits.
  - blink: eff = duty during the on phase, 0 during the off phase.
  - off: eff = 0.
- pwm_out[k] <= (cnt < eff[k]), registered: one clk latency from cnt/eff.
  - duty=0 gives output always 0.
  - duty=2^W-1 gives output always 1 in static mode (cnt never reaches 2^W-1).
- Breathing envelope:
  - Active only while the active mode is 01. Entering 01 from any other mode at a boundary resets level=0 and direction=up.
  - A step occurs every STEP_PERIODS boundaries.
  - Direction up: level+1. When level reaches 2^W-1, direction flips to down.
  - Direction down: level-1. When level reaches 0, direction flips to up.
  - No overflow or wrap ever occurs: full triangle period = 2*(2^W-1)*STEP_PERIODS PWM periods.
  - level holds its value in other modes and is reported unchanged.
- Blink:
  - Phase toggles every BLINK_PERIODS boundaries.
  - Entering 10 resets phase=on and the blink counter=0.
- Mode changes mid-period have no effect until the boundary, so there are no runt pulses.
- Reset asserted mid-period forces all outputs low within the same cycle (async). Operation restarts in off mode.

Test Plan:
1. W=4, PRESCALE=1, static. load duty R=5, G=0, B=15 -> after the next boundary, each 15-clk period shows R high 5 clks, G always 0, B always 1. period_tick pulses every 15 clks.
2. Glitch-free update: load R=3 mid-period, then R=10 two clks later -> the current period keeps the old duty, the next period shows R high 10 clks, and 3 never appears.
3. Breathing, W=4, STEP_PERIODS=1, duty R=15: level runs 0,1,...,15,14,...,0 across 31 boundaries. R high-time per period = (15*level)>>4; level=15 gives 14 clks, level=8 gives 7 clks.
4. Blink, W=4, BLINK_PERIODS=2, duty G=8 -> G high 8 clks in each of 2 periods, then 0 for 2 periods, repeating. Entering blink restarts in the on phase.
5. Off mode and PRESCALE=4: switching to 11 holds pwm_out=0 from the next boundary. The period length measures 60 clks.
6. Async reset asserted mid-high pulse -> pwm_out=0 and level=0 in the same cycle. After release, outputs stay 0 until mode and duty are loaded and a boundary passes.

Source files
------------

// File: rtl/rgb_pwm_engine.sv
// N-channel PWM LED driver with prescaler, shadowed duty updates and
// static / breathing / blink / off lighting modes applied on period boundaries.
module rgb_pwm_engine #(
    parameter int unsigned NUM_CH        = 3,
    parameter int unsigned PWM_WIDTH     = 8,
    parameter int unsigned PRESCALE      = 4,
    parameter int unsigned STEP_PERIODS  = 2,
    parameter int unsigned BLINK_PERIODS = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [1:0]                  mode,
    input  logic [NUM_CH*PWM_WIDTH-1:0] duty_in,
    input  logic                        load,
    output logic [NUM_CH-1:0]           pwm_out,
    output logic                        period_tick,
    output logic [PWM_WIDTH-1:0]        level
);

    localparam int unsigned W   = PWM_WIDTH;
    localparam int unsigned PsW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned StW = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
    localparam int unsigned BlW = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;

    localparam logic [W-1:0]   CntLast     = {{(W-1){1'b1}}, 1'b0};
    localparam logic [W-1:0]   LevelPenult = {{(W-1){1'b1}}, 1'b0};
    localparam logic [PsW-1:0] PsLast      = PsW'(PRESCALE - 1);
    localparam logic [StW-1:0] StLast      = StW'(STEP_PERIODS - 1);
    localparam logic [BlW-1:0] BlLast      = BlW'(BLINK_PERIODS - 1);

    typedef enum logic [1:0] {
        ModeStatic = 2'b00,
        ModeBreath = 2'b01,
        ModeBlink  = 2'b10,
        ModeOff    = 2'b11
    } mode_e;

    logic [PsW-1:0]          presc_q, presc_d;
    logic [W-1:0]            cnt_q, cnt_d;
    logic [NUM_CH*W-1:0]     shadow_q, shadow_d;
    logic [NUM_CH*W-1:0]     duty_act_q, duty_act_d;
    mode_e                   mode_act_q, mode_act_d;
    logic [W-1:0]            level_q, level_d;
    logic                    dir_down_q, dir_down_d;
    logic [StW-1:0]          step_q, step_d;
    logic                    phase_on_q, phase_on_d;
    logic [BlW-1:0]          blink_q, blink_d;
    logic                    tick_q, tick_d;
    logic [NUM_CH-1:0]       pwm_q, pwm_d;
    logic                    tick;
    logic                    boundary;
    mode_e                   mode_in;

    assign tick     = (presc_q == PsLast);
    assign boundary = tick && (cnt_q == CntLast);
    assign mode_in  = mode_e'(mode);

    always_comb begin
        presc_d    = tick ? '0 : presc_q + PsW'(1);
        cnt_d      = cnt_q;
        shadow_d   = load ? duty_in : shadow_q;
        duty_act_d = duty_act_q;
        mode_act_d = mode_act_q;
        level_d    = level_q;
        dir_down_d = dir_down_q;
        step_d     = step_q;
        phase_on_d = phase_on_q;
        blink_d    = blink_q;
        tick_d     = boundary;

        if (tick) begin
            cnt_d = (cnt_q == CntLast) ? '0 : cnt_q + W'(1);
        end

        // Shadow is sampled before any coincident load lands, so such a load waits one period.
        if (boundary) begin
            duty_act_d = shadow_q;
            mode_act_d = mode_in;

            if (mode_in == ModeBreath) begin
                if (mode_act_q != ModeBreath) begin
                    level_d    = '0;
                    dir_down_d = 1'b0;
                    step_d     = '0;
                end else if (step_q == StLast) begin
                    step_d = '0;
                    if (!dir_down_q) begin
                        level_d = level_q + W'(1);
                        if (level_q == LevelPenult) dir_down_d = 1'b1;
                    end else begin
                        level_d = level_q - W'(1);
                        if (level_q == W'(1)) dir_down_d = 1'b0;
                    end
                end else begin
                    step_d = step_q + StW'(1);
                end
            end

            if (mode_in == ModeBlink) begin
                if (mode_act_q != ModeBlink) begin
                    phase_on_d = 1'b1;
                    blink_d    = '0;
                end else if (blink_q == BlLast) begin
                    phase_on_d = ~phase_on_q;
                    blink_d    = '0;
                end else begin
                    blink_d = blink_q + BlW'(1);
                end
            end
        end
    end

    always_comb begin
        logic [W-1:0]   duty_k;
        logic [W-1:0]   eff_k;
        logic [2*W-1:0] prod_k;
        pwm_d = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            duty_k = duty_act_q[k*W +: W];
            prod_k = {{W{1'b0}}, duty_k} * {{W{1'b0}}, level_q};
            unique case (mode_act_q)
                ModeStatic: eff_k = duty_k;
                ModeBreath: eff_k = prod_k[2*W-1:W];
                ModeBlink:  eff_k = phase_on_q ? duty_k : '0;
                default:    eff_k = '0;
            endcase
            pwm_d[k] = (cnt_q < eff_k);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q    <= '0;
            cnt_q      <= '0;
            shadow_q   <= '0;
            duty_act_q <= '0;
            mode_act_q <= ModeOff;
            level_q    <= '0;
            dir_down_q <= 1'b0;
            step_q     <= '0;
            phase_on_q <= 1'b1;
            blink_q    <= '0;
            tick_q     <= 1'b0;
            pwm_q      <= '0;
        end else begin
            presc_q    <= presc_d;
            cnt_q      <= cnt_d;
            shadow_q   <= shadow_d;
            duty_act_q <= duty_act_d;
            mode_act_q <= mode_act_d;
            level_q    <= level_d;
            dir_down_q <= dir_down_d;
            step_q     <= step_d;
            phase_on_q <= phase_on_d;
            blink_q    <= blink_d;
            tick_q     <= tick_d;
            pwm_q      <= pwm_d;
        end
    end

    assign pwm_out     = pwm_q;
    assign period_tick = tick_q;
    assign level       = level_q;

endmodule

// File: tb/tb_rgb_pwm_engine.sv
// Directed bench for rgb_pwm_engine: W=4 instance with PRESCALE=1 and a
// second instance with PRESCALE=4 for period-length and off-mode checks.
module tb_rgb_pwm_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  mode_a, mode_b;
    logic [11:0] duty_a, duty_b;
    logic        load_a, load_b;
    logic [2:0]  pwm_a, pwm_b;
    logic        tick_a, tick_b;
    logic [3:0]  level_a, level_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rgb_pwm_engine #(
        .NUM_CH(3), .PWM_WIDTH(4), .PRESCALE(1), .STEP_PERIODS(1), .BLINK_PERIODS(2)
    ) u_dut_a (
        .clk(clk), .rst(rst), .mode(mode_a), .duty_in(duty_a), .load(load_a),
        .pwm_out(pwm_a), .period_tick(tick_a), .level(level_a)
    );

    rgb_pwm_engine #(
        .NUM_CH(3), .PWM_WIDTH(4), .PRESCALE(4), .STEP_PERIODS(1), .BLINK_PERIODS(2)
    ) u_dut_b (
        .clk(clk), .rst(rst), .mode(mode_b), .duty_in(duty_b), .load(load_b),
        .pwm_out(pwm_b), .period_tick(tick_b), .level(level_b)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive duty for dut a and strobe load for one clk (consumes one negedge).
    task automatic load_a_duty(input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
        duty_a = {b, g, r};
        load_a = 1'b1;
        @(negedge clk);
        load_a = 1'b0;
    endtask

    // Advance to the next clk where period_tick is high (bounded).
    task automatic wait_tick_a();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tick_a && n < 100);
        check("wait_tick_a", (n < 100) ? 1 : 0, 1);
    endtask

    // Called on a period_tick clk; counts one period of output (1 clk lag) and
    // ends on the next period_tick clk.
    task automatic measure_a(output int hr, output int hg, output int hb, output int nt);
        hr = 0; hg = 0; hb = 0; nt = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            hr += int'(pwm_a[0]);
            hg += int'(pwm_a[1]);
            hb += int'(pwm_a[2]);
            nt += int'(tick_a);
        end
    endtask

    // From a period_tick clk of dut b, count clks and R high-time until the next one.
    task automatic period_b(output int len, output int hr);
        len = 0; hr = 0;
        do begin
            @(negedge clk);
            len++;
            hr += int'(pwm_b[0]);
        end while (!tick_b && len < 200);
    endtask

    initial begin
        int hr, hg, hb, nt, lv, n, hi, len;

        rst = 1'b1;
        mode_a = 2'b11; duty_a = '0; load_a = 1'b0;
        mode_b = 2'b11; duty_b = '0; load_b = 1'b0;
        #12;
        check("reset_pwm", int'(pwm_a), 0);
        check("reset_tick", int'(tick_a), 0);
        check("reset_level", int'(level_a), 0);
        @(negedge clk);
        rst = 1'b0;

        // Static: R=5, G=0, B=15
        mode_a = 2'b00;
        load_a_duty(4'd5, 4'd0, 4'd15);
        wait_tick_a();
        for (int p = 0; p < 2; p++) begin
            measure_a(hr, hg, hb, nt);
            check("static_r", hr, 5);
            check("static_g", hg, 0);
            check("static_b", hb, 15);
            check("static_ticks", nt, 1);
            check("static_tick_end", int'(tick_a), 1);
        end

        // Two loads mid-period: last wins, current period unchanged
        fork
            measure_a(hr, hg, hb, nt);
            begin
                repeat (3) @(negedge clk);
                load_a_duty(4'd3, 4'd0, 4'd15);
                @(negedge clk);
                load_a_duty(4'd10, 4'd0, 4'd15);
            end
        join
        check("shadow_cur_r", hr, 5);
        check("shadow_cur_b", hb, 15);
        measure_a(hr, hg, hb, nt);
        check("shadow_next_r", hr, 10);
        measure_a(hr, hg, hb, nt);
        check("shadow_next2_r", hr, 10);

        // Breathing triangle with R=15
        mode_a = 2'b01;
        load_a_duty(4'd15, 4'd0, 4'd0);
        wait_tick_a();
        for (int i = 0; i <= 30; i++) begin
            lv = (i <= 15) ? i : 30 - i;
            check($sformatf("breath_level_%0d", i), int'(level_a), lv);
            measure_a(hr, hg, hb, nt);
            check($sformatf("breath_r_%0d", i), hr, (15 * lv) >> 4);
        end
        check("breath_level_wrap", int'(level_a), 1);

        // Blink G=8, then leave and re-enter blink while phase is off
        mode_a = 2'b10;
        load_a_duty(4'd0, 4'd8, 4'd0);
        wait_tick_a();
        measure_a(hr, hg, hb, nt);
        check("blink_p0_g", hg, 8);
        check("blink_p0_r", hr, 0);
        measure_a(hr, hg, hb, nt);
        check("blink_p1_g", hg, 8);
        mode_a = 2'b00;
        measure_a(hr, hg, hb, nt);
        check("blink_p2_g", hg, 0);
        mode_a = 2'b10;
        measure_a(hr, hg, hb, nt);
        check("blink_static_g", hg, 8);
        measure_a(hr, hg, hb, nt);
        check("blink_reenter_g", hg, 8);
        measure_a(hr, hg, hb, nt);
        check("blink_reenter2_g", hg, 8);
        measure_a(hr, hg, hb, nt);
        check("blink_reenter_off_g", hg, 0);
        check("level_held", int'(level_a), 1);

        // Async reset mid high pulse
        mode_a = 2'b00;
        load_a_duty(4'd15, 4'd0, 4'd0);
        wait_tick_a();
        repeat (3) @(negedge clk);
        check("pre_reset_pwm", int'(pwm_a), 1);
        #2 rst = 1'b1;
        #1;
        check("async_reset_pwm", int'(pwm_a), 0);
        check("async_reset_level", int'(level_a), 0);
        check("async_reset_tick", int'(tick_a), 0);
        @(negedge clk);
        rst = 1'b0;
        hi = 0; n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            hi += int'(pwm_a != 3'b000);
            n  += int'(tick_a);
        end
        check("post_reset_quiet", hi, 0);
        check("post_reset_ticks", n, 2);
        load_a_duty(4'd15, 4'd0, 4'd0);
        wait_tick_a();
        measure_a(hr, hg, hb, nt);
        check("post_reset_reload_r", hr, 15);

        // PRESCALE=4: period length and off mode
        mode_b = 2'b00;
        duty_b = {4'd0, 4'd0, 4'd7};
        load_b = 1'b1;
        @(negedge clk);
        load_b = 1'b0;
        period_b(len, hr);
        check("b_first_tick_found", (len < 200) ? 1 : 0, 1);
        period_b(len, hr);
        check("b_period_len", len, 60);
        check("b_static_r", hr, 28);
        mode_b = 2'b11;
        period_b(len, hr);
        check("b_pre_off_r", hr, 28);
        period_b(len, hr);
        check("b_off_len", len, 60);
        check("b_off_r", hr, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
